ahb_lite_mem_slave: RTL

AHB-Lite responder backed by a word-addressed register-array memory, with a configurable number of wait states and a two-cycle ERROR response. It is the slave end of the bus that the AHB driver in the verification environment initiates transfers on. It sits behind `AHB_if`, so the environment exercises a real responder instead of a passive interface.

---
 rtl/ahb_lite_mem_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_mem_slave
// Purpose  : AHB-Lite responder backed by a word-addressed register-array
//            memory. It inserts WAIT_STATES stall cycles into every OKAY data
//            phase and gives a two-cycle ERROR response for misaligned,
//            oversized or out-of-range transfers.
// Ports    : hclk, hresetn     clock, synchronous active-low reset
//            hsel, haddr, htrans, hwrite, hsize, hburst, hready
//                              address-phase inputs (hburst is ignored)
//            hwdata            write data, valid in the data phase
//            hreadyout, hresp, hrdata
//                              registered data-phase responses
// Revision : 1.0  initial release
// ============================================================================
module ahb_lite_mem_slave #(
  parameter int DATA_WIDTH  = 32,   // only 32 is supported
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,  // words; must be a power of two >= 2
  parameter int WAIT_STATES = 0     // 0..15
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int                  c_IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-3:0] c_DEPTH   = (ADDR_WIDTH-2)'(MEM_DEPTH);
  localparam logic [3:0]          c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [c_IDX_W+1:0]      addr_q, addr_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic                    err_q, err_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    w_accept;
  logic                    w_err;
  logic                    w_commit;
  logic [3:0]              w_be;
  logic [c_IDX_W-1:0]      w_cur_idx;
  logic [c_IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic                    w_unused;

  assign w_unused = &{1'b0, htrans[0], hburst};

  assign w_accept  = hsel & hready & htrans[1];
  assign w_err     = (hsize > 3'd2)
                   | ((hsize == 3'd1) & haddr[0])
                   | ((hsize == 3'd2) & (|haddr[1:0]))
                   | (haddr[ADDR_WIDTH-1:2] >= c_DEPTH);
  assign w_cur_idx = addr_q[c_IDX_W+1:2];
  assign w_commit  = (state_q == S_DATA) & write_q & ~err_q;

  // Byte-lane enables from the registered size and low address bits.
  always_comb begin
    w_be = 4'b0000;
    case (size_q)
      3'd0:    w_be = 4'b0001 << addr_q[1:0];
      3'd1:    w_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Next-state, next-field and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    err_d    = err_q;
    w_rd_idx = w_cur_idx;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 complete on this edge and may take a new phase.
        if (w_accept) begin
          addr_d   = haddr[c_IDX_W+1:0];
          write_d  = hwrite;
          size_d   = hsize;
          err_d    = w_err;
          w_rd_idx = haddr[c_IDX_W+1:2];
          if (w_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = c_WAIT_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Read word with forwarding: a write committing on this edge to the same
  // word must be visible to a read whose data phase starts on this edge.
  always_comb begin
    w_rd_word = mem_q[w_rd_idx];
    for (int b = 0; b < 4; b++) begin
      if (w_commit && w_be[b] && (w_rd_idx == w_cur_idx)) begin
        w_rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = hrdata_q;
    case (state_d)
      S_WAIT: hreadyout_d = 1'b0;
      S_DATA: hrdata_d    = w_rd_word;
      S_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
        hrdata_d    = '0;
      end
      S_ERR2: begin
        hresp_d  = 1'b1;
        hrdata_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      err_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      err_q       <= err_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Memory array is deliberately not reset; a reset edge still blocks a commit.
  always_ff @(posedge hclk) begin
    if (hresetn && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_cur_idx][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

endmodule
`default_nettype wire
